// File: rtl/vga_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_ctrl_if : picture-block coordinate/data link plus monitor-side outputs
// Revision    : 1.0
// ----------------------------------------------------------------------------
interface vga_ctrl_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        rgb_valid;
  logic        frame_start;

  modport master (
    output pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start,
    input  pix_data
  );

  modport slave (
    input  pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start,
    output pix_data
  );
endinterface
`default_nettype wire

// File: rtl/vga_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_ctrl : raster timing generator with 2-stage sync/pixel alignment
// Revision : 1.0
// ----------------------------------------------------------------------------
module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input wire         vga_clk,
  input wire         sys_rst_n,
  vga_ctrl_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [9:0]  H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_OFS      = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  V_OFS      = 10'(V_SYNC + V_BACK);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT_LO   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_HI   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_ACT_LO   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_HI   = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);

  logic [9:0]  r_cnt_h;
  logic [9:0]  r_cnt_v;
  logic [10:0] w_h;
  logic [10:0] w_v;
  logic        w_act;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic        w_first;

  logic [9:0]  r_pix_x;
  logic [9:0]  r_pix_y;
  logic        r_act1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_first1;

  logic [15:0] r_rgb;
  logic        r_rgb_valid;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (r_cnt_h == H_MAX) begin
      r_cnt_h <= '0;
      r_cnt_v <= (r_cnt_v == V_MAX) ? 10'd0 : r_cnt_v + 10'd1;
    end else begin
      r_cnt_h <= r_cnt_h + 10'd1;
    end
  end

  assign w_h     = {1'b0, r_cnt_h};
  assign w_v     = {1'b0, r_cnt_v};
  assign w_act   = (w_h >= H_ACT_LO) && (w_h < H_ACT_HI) &&
                   (w_v >= V_ACT_LO) && (w_v < V_ACT_HI);
  assign w_x     = r_cnt_h - H_OFS;
  assign w_y     = r_cnt_v - V_OFS;
  assign w_first = w_act && (w_x == 10'd0) && (w_y == 10'd0);

  // Stage 1: coordinates go out to the picture block one clock after the counters
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_x  <= 10'h3FF;
      r_pix_y  <= 10'h3FF;
      r_act1   <= 1'b0;
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
      r_first1 <= 1'b0;
    end else begin
      r_pix_x  <= w_act ? w_x : 10'h3FF;
      r_pix_y  <= w_act ? w_y : 10'h3FF;
      r_act1   <= w_act;
      r_hs1    <= (w_h >= H_SYNC_END);
      r_vs1    <= (w_v >= V_SYNC_END);
      r_first1 <= w_first;
    end
  end

  // Stage 2: pix_data is only trusted while act1 is set
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rgb         <= 16'h0000;
      r_rgb_valid   <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= r_act1 ? vga.pix_data : 16'h0000;
      r_rgb_valid   <= r_act1;
      r_hsync       <= r_hs1;
      r_vsync       <= r_vs1;
      r_frame_start <= r_first1;
    end
  end

  assign vga.pix_x       = r_pix_x;
  assign vga.pix_y       = r_pix_y;
  assign vga.rgb         = r_rgb;
  assign vga.rgb_valid   = r_rgb_valid;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/vga_ctrl.md
# vga_ctrl

Raster-timing generator that drives the monitor side of the VGA path and feeds pixel coordinates to the picture generators. It produces hsync/vsync and the active-video window from free-running counters. It also presents pix_x/pix_y to the picture block, which answers combinationally with pix_data. The returned RGB565 data is registered and aligned with the sync outputs through a fixed 2-stage pipeline. Default timing is 640x480@60 Hz on a 25 MHz vga_clk.

## Interface
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, active lines
- V_FRONT, 10, vertical front porch
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  reset; one clock; asynchronous, active-low
- pix_data  in  16  RGB565 from picture block, combinational function of pix_x/pix_y
- pix_x  out  10  active column 0..H_ACTIVE-1, 10'h3FF outside active
- pix_y  out  10  active row 0..V_ACTIVE-1, 10'h3FF outside active
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- rgb  out  16  RGB565 to DAC, 0 outside active
- rgb_valid  out  1  high during active video (aligned with rgb)
- frame_start  out  1  one-cycle pulse with pixel (0,0) on rgb

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800); V_TOTAL likewise (525).
- cnt_h: 0..H_TOTAL-1, +1 every clock, wraps to 0.
- cnt_v: 0..V_TOTAL-1, +1 only when cnt_h = H_TOTAL-1, wraps to 0 when both are at max.
- Each line/frame order: sync, back porch, active, front porch; sync starts at count 0.
- act_c = (H_SYNC+H_BACK <= cnt_h < H_SYNC+H_BACK+H_ACTIVE) and (V_SYNC+V_BACK <= cnt_v < V_SYNC+V_BACK+V_ACTIVE).
- Stage 1 (registered from counters):
  - pix_x = act_c ? cnt_h-(H_SYNC+H_BACK) : 10'h3FF; pix_y analogous.
  - act1 = act_c; hs1 = (cnt_h >= H_SYNC); vs1 = (cnt_v >= V_SYNC).
  - first1 = act_c and pix coordinates (0,0).
- Stage 2 (registered):
  - rgb = act1 ? pix_data : 16'h0000; rgb_valid = act1.
  - hsync = hs1; vsync = vs1; frame_start = first1.
- pix_data is sampled only while act1 = 1; X/garbage outside active must not reach rgb.
- Subtractions are performed at counter width (10 bits for cnt_h/cnt_v); results fit in 10 bits for defaults; parameters must keep H_TOTAL, V_TOTAL <= 1024.

## Timing
- Reset values (asynchronous, immediate on sys_rst_n low):
  - cnt_h = cnt_v = 0; pix_x = pix_y = 10'h3FF.
  - hsync = vsync = 1; rgb = 0; rgb_valid = 0; frame_start = 0.
- Edge k after reset release: counters hold index k (k = cnt_v*H_TOTAL + cnt_h).
- Stage 1 reflects index k after edge k+1; stage 2 after edge k+2.
- Latency counters -> pix_x/pix_y: 1 clock. Counters -> hsync/vsync/rgb/rgb_valid: 2 clocks. Sync and rgb are mutually aligned.
- pix_data must settle within one vga_clk after pix_x/pix_y change.
- Line period H_TOTAL clocks; frame period H_TOTAL*V_TOTAL (420000) clocks.
- Wrap: after (H_TOTAL-1, V_TOTAL-1) the next count is (0,0); no idle cycle.
- Reset mid-frame: all outputs go to reset values at once. Counting restarts from (0,0) on release, so the first full frame begins with a sync pulse.

## Test plan
- Reset release -> hsync falls after edge 2, stays low 96 clocks, period 800; vsync falls after edge 2, low 1600 clocks, period 420000.
- Active window -> rgb_valid first rises after edge 28146 (index 35*800+144 + 2), high 640 clocks per line, 480 lines per frame; frame_start pulses once, same cycle.
- Coordinate check -> pix_x runs 0..639 then 10'h3FF; pix_y 0..479; both 10'h3FF in blanking; pix_x leads rgb by exactly 1 clock.
- Data path: stub pix_data = {pix_y[5:0], pix_x[9:0]} -> rgb on each valid cycle equals the stub of the coordinates presented 1 clock earlier; rgb = 0 whenever rgb_valid = 0, even with pix_data forced 16'hFFFF.
- Reset asserted at line 200 col 300 -> outputs take reset values without waiting for a clock edge; after release, hsync timing matches the first scenario.
- Small parameters (H 2/2/4/2, V 1/1/3/1) -> two consecutive frames match the computed counts exactly, including wrap at (9,5) -> (0,0).
